// File: rtl/demux_dispatch_pkg.sv
// Shared constants and types for the demux dispatcher.
package dispatch_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 8;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_next_sel.sv
// Rotating priority picker: first enabled channel at or after rr_ptr, wrapping.
module rr_next_sel
  import dispatch_pkg::*;
(
  input  logic [NUM_CH-1:0] ch_en,
  input  sel_t              rr_ptr,
  output sel_t              cand,
  output logic              found
);

  sel_t idx;

  // Scan channels starting at rr_ptr; the select width wraps the index modulo NUM_CH.
  always_comb begin
    found = 1'b0;
    cand  = rr_ptr;
    idx   = rr_ptr;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = rr_ptr + sel_t'(i);
      if (!found && ch_en[idx]) begin
        found = 1'b1;
        cand  = idx;
      end
    end
  end

endmodule

// File: rtl/demux_dispatch.sv
// Single-entry output stage feeding a 4-way demux, with round-robin or fixed
// channel selection and per-channel backpressure.
module demux_dispatch
  import dispatch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic              mode,
  input  logic [SEL_W-1:0]  fixed_sel,
  output logic [DATA_W-1:0] dmx_in,
  output logic [SEL_W-1:0]  dmx_sel,
  output logic              dmx_valid,
  output logic [CNT_W-1:0]  dispatch_cnt
);

  state_t state, state_nxt;
  sel_t   rr_ptr;
  sel_t   rr_cand;
  logic   rr_found;
  sel_t   cand;
  logic   cand_ok;
  logic   drain;
  logic   accept;

  rr_next_sel u_rr (
    .ch_en  (ch_en),
    .rr_ptr (rr_ptr),
    .cand   (rr_cand),
    .found  (rr_found)
  );

  // Candidate channel for the next accepted word.
  always_comb begin
    cand    = rr_cand;
    cand_ok = rr_found;
    if (mode) begin
      cand    = fixed_sel;
      cand_ok = ch_en[fixed_sel];
    end
  end

  assign dmx_valid = (state == FULL);
  assign drain     = dmx_valid & ch_ready[dmx_sel];
  assign s_ready   = cand_ok & (~dmx_valid | drain);
  assign accept    = s_valid & s_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Next-state logic: accept fills the stage, a drain without accept empties it.
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (accept) state_nxt = FULL;
      FULL:  if (drain && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Output register, round-robin pointer and delivered-word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmx_in       <= '0;
      dmx_sel      <= '0;
      rr_ptr       <= '0;
      dispatch_cnt <= '0;
    end else begin
      if (accept) begin
        dmx_in  <= s_data;
        dmx_sel <= cand;
        if (!mode) rr_ptr <= cand + sel_t'(1);
      end
      if (drain) dispatch_cnt <= dispatch_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/demux_dispatch.md
Name: demux_dispatch

Overview:
- Upstream feeder for the 4-way, 4-bit demux.
- Accepts a valid/ready stream of 4-bit words and registers each word together with a channel select.
- Drives the demux `in`/`sel` inputs, plus a valid flag for the consumers behind the demux.
- Channel choice is round-robin over enabled channels or a fixed channel; the output is back-pressured per channel.

Parameters:
- DATA_W, 4, width of data word and of the demux data path.
- NUM_CH, 4, number of demux outputs; fixed at 4.
- SEL_W, 2, select width, equal to log2(NUM_CH).
- CNT_W, 8, width of the dispatched-word counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  upstream word valid.
- s_ready  output  1  block can accept a word this cycle.
- s_data  input  DATA_W  upstream word.
- ch_en  input  NUM_CH  per-channel enable mask; bit k enables channel k.
- ch_ready  input  NUM_CH  per-channel consumer ready.
- mode  input  1  0 = round-robin, 1 = fixed channel.
- fixed_sel  input  SEL_W  channel used when mode=1.
- dmx_in  output  DATA_W  data to the demux `in` port.
- dmx_sel  output  SEL_W  select to the demux `sel` port.
- dmx_valid  output  1  dmx_in/dmx_sel hold a word not yet taken.
- dispatch_cnt  output  CNT_W  total words delivered to consumers.

Behaviour:
- Reset, sampled on a rising edge with rst=1:
  - dmx_valid=0, dmx_in=0, dmx_sel=0, dispatch_cnt=0, rr_ptr=0, FSM=EMPTY.
  - Reset overrides all other inputs that cycle; a word in flight is discarded.
- Output register is a single-entry pipeline stage. FSM states are EMPTY (dmx_valid=0) and FULL (dmx_valid=1).
- Candidate channel `cand`, combinational:
  - mode=0: the lowest channel index at or after rr_ptr, wrapping 3→0, whose ch_en bit is 1.
  - mode=1: fixed_sel.
  - `cand_ok` = 1 when such a channel exists (mode=0) or when ch_en[fixed_sel]=1 (mode=1).
- Drain: drain = dmx_valid & ch_ready[dmx_sel]. It is judged only against the registered dmx_sel.
- s_ready = cand_ok & (~dmx_valid | drain). This is combinational, with no extra bubble.
- Accept: accept = s_valid & s_ready. On accept, the next edge loads dmx_in <= s_data, dmx_sel <= cand, dmx_valid <= 1.
  - In mode=0 only, rr_ptr <= (cand+1) mod 4.
- Transitions:
  - EMPTY→FULL on accept.
  - FULL→FULL on drain & accept: back-to-back transfer, a new word every cycle.
  - FULL→EMPTY on drain & ~accept.
  - FULL holds while ~drain; dmx_in/dmx_sel stay stable while held.
- Latency: an accepted word appears on dmx_* the cycle after acceptance. Full throughput is 1 word per cycle.
- dispatch_cnt increments by 1 on each drain and wraps 2^CNT_W-1 → 0.
- dmx_in/dmx_sel keep their last value when dmx_valid=0.
- Boundary conditions:
  - ch_en=0 (mode 0), or the fixed channel disabled: s_ready=0. A held word still drains.
  - A ch_en or mode change while FULL does not affect the held word. It applies to the next accept only.
  - mode=1 leaves rr_ptr unchanged. Returning to mode 0 resumes from the stored rr_ptr.
  - A ch_ready bit for any channel other than dmx_sel is ignored.
  - s_data is ignored when s_valid=0.

Decomposition:
- Package `dispatch_pkg` holds:
  - constants DATA_W, NUM_CH, SEL_W, CNT_W;
  - the state enum {EMPTY, FULL};
  - the select type logic [SEL_W-1:0].
- One sub-module, `rr_next_sel`: a combinational rotating priority picker.
  - Inputs: ch_en, rr_ptr.
  - Outputs: cand, found.
- The top module holds the FSM, output register, pointer and counter.

Test Plan:
- Reset and round-robin: rst for 2 cycles, then ch_en=4'hF, ch_ready=4'hF, mode=0, and send 8,1,2,3,4 back-to-back → dmx_sel=0,1,2,3,0 on consecutive cycles; dmx_in matches; s_ready stays 1; dispatch_cnt=5.
- Masked channels: ch_en=4'b1010, send 5 words → dmx_sel sequence 1,3,1,3,1; ch_en=0 → s_ready=0 and dmx_valid=0 after the held word drains.
- Backpressure: ch_ready=4'b1110, send 4'h8 routed to channel 0 → dmx_valid=1, dmx_in=8, dmx_sel=0 held stable and s_ready=0 for 5 cycles; raise ch_ready[0] → one drain, count+1.
- Fixed mode: mode=1, fixed_sel=2, send 3 words → dmx_sel=2 for all; rr_ptr unchanged; switch to mode=0 → next word takes the stored rr_ptr channel.
- Reset mid-operation: FULL with ch_ready=0, assert rst for 1 cycle → dmx_valid=0, dmx_in=0, dmx_sel=0, dispatch_cnt=0; the next word goes to channel 0.
- Counter wrap: 256 consecutive transfers → dispatch_cnt returns to 0.
